stream_alu: RTL and testbench
=============================

// Module: stream_alu
// PURPOSE
//  Parametrised streaming ALU: a valid/ready successor to the execute/done ALU.
//  - Accepts one operation per cycle and returns a tagged result with Z/N/C/V flags.
//  - Runs multiply as an iterative shift-add over WIDTH cycles.
//  - Sits between an operand issue queue and a result writeback stage; both sides may stall.
// PARAMETERS
//  WIDTH   8                  operand/result width, >= 4
//  TAG_W   4                  width of caller tag carried through unchanged
//  SHW     $clog2(WIDTH)      shift-amount width (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation offered
//  in_ready   out  1      operation accepted when in_valid & in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  opcode     in   4      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 CMP, 9 MUL, A SAR
//  tag        in   TAG_W  caller tag
//  out_valid  out  1      result held until out_ready
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  result     out  WIDTH  result
//  flags      out  4      [3]Z [2]N [1]C [0]V
//  out_tag    out  TAG_W  tag of the accepted op
//  out_err    out  1      illegal opcode reported with this result
//  busy       out  1      iterative multiply in progress
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE. Reset mid-MUL abandons the op and no result is emitted.
//  - FSM states IDLE and MUL.
//    - IDLE to MUL: on accept with opcode 9.
//    - MUL to IDLE: after WIDTH iterations, loading the output register.
//  - in_ready = (state==IDLE) & (!out_valid | out_ready).
//    - A same-cycle drain and accept is legal.
//    - Peak throughput is 1 op/clk for single-cycle ops.
//  - Latency, accept edge to out_valid:
//    - Single-cycle ops: 1 clk.
//    - MUL: WIDTH+1 clk.
//  - MUL always completes into an empty output slot, because accept requires that slot to drain.
//  - Output hold: result, flags, out_tag and out_err are stable while out_valid & !out_ready.
//  - out_valid clears on a drain with no new result.
//  - ADD: C = carry out, V = signed overflow.
//  - SUB: C = borrow (a<b unsigned), V = signed overflow.
//  - CMP: flags as SUB, result = a unchanged.
//  - AND, OR, XOR, NOT: C = V = 0.
//  - SHL, SHR, SAR: shift by b[SHW-1:0].
//    - C = last bit shifted out; amount 0 gives result = a and C = 0.
//    - V = 0.
//    - SAR replicates a[WIDTH-1].
//  - MUL: unsigned; result = low WIDTH bits of the product.
//    - C = V = 1 if the high WIDTH bits are nonzero.
//  - Z = (result==0) and N = result[WIDTH-1] for all ops, including CMP on a-b.
//  - Illegal opcode (B-F): result 0, flags 0000, out_err = 1, latency 1.
//  - out_err is 0 for all legal ops.
//  - in_valid with !in_ready is ignored; the producer must hold its inputs.
// CONFIGURATION
//  STREAM_ALU_MUL_EN defined:
//  - Shift-add multiplier, MUL state and busy are implemented as above.
//  STREAM_ALU_MUL_EN undefined:
//  - No multiplier logic; opcode 9 is treated as illegal (out_err = 1, latency 1).
//  - The FSM never leaves IDLE and busy ties to 0.
// TESTING (WIDTH=8)
//  1. ADD 7F+01, tag 3 -> result 80, flags 0101, out_tag 3, one clk after accept.
//     ADD FF+01 -> result 00, flags 1010.
//  2. SUB 00-01 -> result FF, flags 0110.
//     CMP 05,05 -> result 05, flags 1000.
//     CMP 05,08 -> result 05, flags 0110.
//  3. SHL 81 by 1 -> result 02, flags 0010.
//     SAR 80 by 3 -> result F0, flags 0100.
//     SHR 81 by 0 -> result 81, flags 0100.
//  4. MUL 10*10 -> result 00, flags 1011, busy for 8 clk, out_valid 9 clk after accept.
//     MUL 04*05 -> result 14, flags 0000.
//  5. Throughput and backpressure:
//     - 4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive clks.
//     - Hold out_ready=0 for 5 clk -> in_ready=0 and the result stays stable.
//     - Release out_ready -> drain and next accept occur on the same clk.
//  6. Reset and illegal opcode:
//     - Drop rst_n at iteration 3 of MUL -> out_valid=0, busy=0, in_ready=1 after release.
//     - Opcode F -> result 00, flags 0000, out_err=1.
//     - With STREAM_ALU_MUL_EN undefined, opcode 9 -> out_err=1.

Source files
------------

// File: rtl/stream_alu.sv
// stream_alu: valid/ready streaming ALU returning a tagged result with Z/N/C/V flags.
// Single-cycle ops land in a one-entry output slot; MUL is an iterative shift-add.
// Build option STREAM_ALU_MUL_EN: when defined, the shift-add multiplier, MUL state
// and busy are present; when undefined, opcode 9 is reported as illegal and busy is 0.
module stream_alu #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);
  // state  | meaning
  // S_IDLE | accepting ops, single-cycle results go straight to the output slot
  // S_MUL  | shift-add iterations running, input side stalled
`ifdef STREAM_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                         OP_CMP = 4'h8, OP_MUL = 4'h9, OP_SAR = 4'hA;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  state_t state, state_nx;

  logic              accept, is_mul_op, load_single, mul_last, mul_done;
  logic [WIDTH-1:0]  mul_res;
  logic [3:0]        mul_flags;
  logic [TAG_W-1:0]  mul_tag;

  logic [WIDTH-1:0]  alu_res, zn_src;
  logic [3:0]        alu_flags;
  logic              alu_err, c, v;
  logic [SHW-1:0]    sh;
  logic [WIDTH:0]    sum, dif, shl, shr;
  logic signed [WIDTH:0] sar;

  // Extra bit on each shift captures the last bit shifted out; amount 0 shifts out 0.
  assign sh  = b[SHW-1:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign shl = {1'b0, a} << sh;
  assign shr = {a, 1'b0} >> sh;
  assign sar = $signed({a, 1'b0}) >>> sh;

  // Single-cycle ALU: result, carry/overflow and illegal-opcode decode.
  always_comb begin
    alu_res = '0;
    c       = 1'b0;
    v       = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        c       = sum[WIDTH];
        v       = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = (opcode == OP_CMP) ? a : dif[WIDTH-1:0];
        c       = dif[WIDTH];
        v       = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = shl[WIDTH-1:0];
        c       = shl[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr[WIDTH:1];
        c       = shr[0];
      end
      OP_SAR: begin
        alu_res = sar[WIDTH:1];
        c       = sar[0];
      end
      default: alu_err = 1'b1;
    endcase
    // CMP reports Z/N of the difference while passing a through.
    zn_src    = (opcode == OP_CMP) ? dif[WIDTH-1:0] : alu_res;
    alu_flags = alu_err ? 4'b0000 : {zn_src == '0, zn_src[WIDTH-1], c, v};
  end

`ifdef STREAM_ALU_MUL_EN
  logic                 mul_start;
  logic [2*WIDTH-1:0]   mul_acc, mul_mcand, acc_nx;
  logic [WIDTH-1:0]     mul_mplier;
  logic [SHW-1:0]       mul_cnt;

  assign mul_start = accept && is_mul_op;
  assign acc_nx    = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last  = (mul_cnt == '0);
  assign mul_res   = acc_nx[WIDTH-1:0];
  assign mul_flags = {mul_res == '0, mul_res[WIDTH-1],
                      |acc_nx[2*WIDTH-1:WIDTH], |acc_nx[2*WIDTH-1:WIDTH]};

  // Shift-add: one multiplier bit per clock, LSB first; down-counter marks the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_tag    <= '0;
    end else if (mul_start) begin
      mul_acc    <= '0;
      mul_mcand  <= {{WIDTH{1'b0}}, a};
      mul_mplier <= b;
      mul_cnt    <= SHW'(WIDTH - 1);
      mul_tag    <= tag;
    end else if (state == S_MUL) begin
      mul_acc    <= acc_nx;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt - 1'b1;
    end
  end
`else
  assign mul_last  = 1'b1;
  assign mul_res   = '0;
  assign mul_flags = 4'b0000;
  assign mul_tag   = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state: enter MUL on accepting a multiply, leave after the last iteration.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && is_mul_op) state_nx = S_MUL;
      S_MUL:   if (mul_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake and control outputs; accept needs the output slot empty or draining.
  always_comb begin
    is_mul_op   = MUL_EN && (opcode == OP_MUL);
    in_ready    = (state == S_IDLE) && (!out_valid || out_ready);
    accept      = in_valid && in_ready;
    load_single = accept && !is_mul_op;
    mul_done    = (state == S_MUL) && mul_last;
    busy        = MUL_EN && (state == S_MUL);
  end

  // Output slot: load a new result, otherwise clear valid when the consumer drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flags     <= alu_flags;
      out_tag   <= tag;
      out_err   <= alu_err;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_res;
      flags     <= mul_flags;
      out_tag   <= mul_tag;
      out_err   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_alu.sv
// tb_stream_alu: directed vectors; expected results queued at accept time and
// compared by an independent monitor whenever the DUT hands over a result.
module tb_stream_alu;
  localparam int WIDTH = 8;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [3:0]       opcode = 4'h0;
  logic [TAG_W-1:0] tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  stream_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
    logic [TAG_W-1:0] tg;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every handed-over result must match the oldest queued expectation.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          n = nameq.pop_front();
          chk({n, ".result"}, 32'(result), 32'(e.res));
          chk({n, ".flags"}, 32'(flags), 32'(e.flg));
          chk({n, ".out_tag"}, 32'(out_tag), 32'(e.tg));
          chk({n, ".out_err"}, 32'(out_err), 32'(e.err));
          if (e.lat != 0) chk({n, ".latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $fatal(1, "watchdog");
  end

  // Offer one op (called just after a rising edge); queue its expectation once accepted.
  task automatic send(string name, logic [3:0] op, logic [WIDTH-1:0] aa, logic [WIDTH-1:0] bb,
                      logic [TAG_W-1:0] tg, logic [WIDTH-1:0] eres, logic [3:0] eflg,
                      logic eerr, int lat, bit expect_out, output int waits);
    exp_t e;
    in_valid = 1'b1; opcode = op; a = aa; b = bb; tag = tg;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({name, ".accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.res = eres; e.flg = eflg; e.tg = tg; e.err = eerr; e.lat = lat; e.acc = cyc;
    if (expect_out) begin
      sbq.push_back(e);
      nameq.push_back(name);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, c0, nb;

    // Reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    chk("rst.out_tag", 32'(out_tag), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // Arithmetic / logic / shift vectors, out_ready held high
    send("add_7f_01", 4'h0, 8'h7F, 8'h01, 4'h3, 8'h80, 4'b0101, 1'b0, 1, 1, w);
    send("add_ff_01", 4'h0, 8'hFF, 8'h01, 4'h1, 8'h00, 4'b1010, 1'b0, 1, 1, w);
    send("sub_00_01", 4'h1, 8'h00, 8'h01, 4'h2, 8'hFF, 4'b0110, 1'b0, 1, 1, w);
    send("sub_80_01", 4'h1, 8'h80, 8'h01, 4'h4, 8'h7F, 4'b0001, 1'b0, 1, 1, w);
    send("cmp_05_05", 4'h8, 8'h05, 8'h05, 4'h5, 8'h05, 4'b1000, 1'b0, 1, 1, w);
    send("cmp_05_08", 4'h8, 8'h05, 8'h08, 4'h6, 8'h05, 4'b0110, 1'b0, 1, 1, w);
    send("and_f0_3c", 4'h2, 8'hF0, 8'h3C, 4'h7, 8'h30, 4'b0000, 1'b0, 1, 1, w);
    send("or_0f_f0",  4'h3, 8'h0F, 8'hF0, 4'h8, 8'hFF, 4'b0100, 1'b0, 1, 1, w);
    send("xor_aa_aa", 4'h4, 8'hAA, 8'hAA, 4'h9, 8'h00, 4'b1000, 1'b0, 1, 1, w);
    send("not_00",    4'h5, 8'h00, 8'h5A, 4'hA, 8'hFF, 4'b0100, 1'b0, 1, 1, w);
    send("shl_81_1",  4'h6, 8'h81, 8'h01, 4'hB, 8'h02, 4'b0010, 1'b0, 1, 1, w);
    send("shl_81_b9", 4'h6, 8'h81, 8'h09, 4'hC, 8'h02, 4'b0010, 1'b0, 1, 1, w);
    send("sar_80_3",  4'hA, 8'h80, 8'h03, 4'hD, 8'hF0, 4'b0100, 1'b0, 1, 1, w);
    send("sar_81_7",  4'hA, 8'h81, 8'h07, 4'hE, 8'hFF, 4'b0100, 1'b0, 1, 1, w);
    send("shr_81_0",  4'h7, 8'h81, 8'h00, 4'hF, 8'h81, 4'b0100, 1'b0, 1, 1, w);
    send("shr_81_1",  4'h7, 8'h81, 8'h01, 4'h0, 8'h40, 4'b0010, 1'b0, 1, 1, w);
    send("illegal_f", 4'hF, 8'h12, 8'h34, 4'h1, 8'h00, 4'b0000, 1'b1, 1, 1, w);
    send("illegal_b", 4'hB, 8'hFF, 8'hFF, 4'h2, 8'h00, 4'b0000, 1'b1, 1, 1, w);
    idle(2);
    chk("drain_clears_valid", 32'(out_valid), 32'd0);

    // Back-to-back throughput
    c0 = cyc;
    send("b2b_0", 4'h0, 8'h01, 8'h02, 4'h1, 8'h03, 4'b0000, 1'b0, 1, 1, w);
    send("b2b_1", 4'h0, 8'h10, 8'h20, 4'h2, 8'h30, 4'b0000, 1'b0, 1, 1, w);
    send("b2b_2", 4'h0, 8'h80, 8'h80, 4'h3, 8'h00, 4'b1011, 1'b0, 1, 1, w);
    send("b2b_3", 4'h0, 8'h7F, 8'h7F, 4'h4, 8'hFE, 4'b0101, 1'b0, 1, 1, w);
    chk("b2b_cycles", 32'(cyc - c0), 32'd4);
    idle(2);

    // Backpressure: slot held, producer stalled, then drain + accept on one edge
    out_ready = 1'b0;
    send("bp_a", 4'h0, 8'h11, 8'h22, 4'h7, 8'h33, 4'b0000, 1'b0, 0, 1, w);
    in_valid = 1'b1; opcode = 4'h0; a = 8'h40; b = 8'h40; tag = 4'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.result_hold", 32'(result), 32'h33);
      chk("bp.flags_hold", 32'(flags), 32'd0);
      chk("bp.tag_hold", 32'(out_tag), 32'h7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send("bp_b", 4'h0, 8'h40, 8'h40, 4'h8, 8'h80, 4'b0101, 1'b0, 1, 1, w);
    chk("bp.same_clk_accept_waits", 32'(w), 32'd0);
    idle(2);

`ifdef STREAM_ALU_MUL_EN
    // Multiply: busy window and latency
    send("mul_10x10", 4'h9, 8'h10, 8'h10, 4'h5, 8'h00, 4'b1011, 1'b0, 9, 1, w);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    chk("mul.busy_cycles", 32'(nb), 32'd8);
    idle(2);
    send("mul_04x05", 4'h9, 8'h04, 8'h05, 4'h6, 8'h14, 4'b0000, 1'b0, 9, 1, w);
    idle(12);
    send("mul_ff_ff", 4'h9, 8'hFF, 8'hFF, 4'h9, 8'h01, 4'b0011, 1'b0, 9, 1, w);
    idle(12);

    // Reset during iteration 3 abandons the op
    send("mul_rst", 4'h9, 8'h03, 8'h07, 4'hA, 8'h15, 4'b0000, 1'b0, 0, 0, w);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mul_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mul_rst.busy", 32'(busy), 32'd0);
    chk("mul_rst.in_ready", 32'(in_ready), 32'd1);
    idle(12);
    chk("mul_rst.no_result", 32'(out_valid), 32'd0);
`else
    // Without the multiplier, opcode 9 is illegal with single-cycle latency
    send("mul_illegal", 4'h9, 8'h10, 8'h10, 4'h6, 8'h00, 4'b0000, 1'b1, 1, 1, w);
    @(negedge clk);
    chk("mul_illegal.busy", 32'(busy), 32'd0);
    idle(2);
`endif

    send("final_add", 4'h0, 8'h22, 8'h11, 4'hC, 8'h33, 4'b0000, 1'b0, 1, 1, w);
    idle(3);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
